// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// csr_trap_unit : machine-mode CSR file, ECALL/interrupt trap entry and MRET.
// Revision 1.0
// ============================================================================
module csr_trap_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] instr_pc,
    input  logic            is_csr_instr,
    input  logic            csr_write,
    input  logic [2:0]      func3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            is_mret_instr,
    input  logic            is_ecall_instr,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_meie;
    logic            mie_mtie;
    logic [XLEN-1:2] mtvec;
    logic [XLEN-1:2] mepc;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mcause;

    logic            accept;
    logic            ext_pending;
    logic            timer_pending;
    logic            take_trap;
    logic            take_mret;
    logic            take_csr;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] csr_new;
    logic            csr_we;
    logic            unused_func3;

    assign unused_func3 = func3[2];

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[12:11] = 2'b11;
                csr_rdata[7]     = mstatus_mpie;
                csr_rdata[3]     = mstatus_mie;
            end
            ADDR_MIE: begin
                csr_rdata[11] = mie_meie;
                csr_rdata[7]  = mie_mtie;
            end
            ADDR_MTVEC:    csr_rdata = {mtvec, 2'b00};
            ADDR_MSCRATCH: csr_rdata = mscratch;
            ADDR_MEPC:     csr_rdata = {mepc, 2'b00};
            ADDR_MCAUSE:   csr_rdata = mcause;
            ADDR_MIP: begin
                csr_rdata[11] = ext_irq;
                csr_rdata[7]  = timer_irq;
            end
            default: ;
        endcase
    end

    // Priority: ECALL > external > timer > MRET > CSR op, one event per cycle.
    assign accept        = instr_valid & ~stall & (state == ST_IDLE);
    assign ext_pending   = mstatus_mie & mie_meie & ext_irq;
    assign timer_pending = mstatus_mie & mie_mtie & timer_irq;
    assign take_trap     = accept & (is_ecall_instr | ext_pending | timer_pending);
    assign take_mret     = accept & ~take_trap & is_mret_instr;
    assign take_csr      = accept & ~take_trap & ~is_mret_instr & is_csr_instr & csr_write;
    assign trap_cause    = is_ecall_instr ? CAUSE_ECALL :
                           ext_pending    ? CAUSE_EXT   : CAUSE_TIMER;

    always_comb begin
        csr_new = csr_rdata;
        csr_we  = 1'b0;
        case (func3[1:0])
            2'b01: begin
                csr_new = csr_wdata;
                csr_we  = take_csr;
            end
            2'b10: begin
                csr_new = csr_rdata | csr_wdata;
                csr_we  = take_csr & (|csr_wdata);
            end
            2'b11: begin
                csr_new = csr_rdata & ~csr_wdata;
                csr_we  = take_csr & (|csr_wdata);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= RESET_MTVEC[XLEN-1:2];
            mepc         <= '0;
            mscratch     <= '0;
            mcause       <= '0;
        end else if (take_trap) begin
            mepc         <= instr_pc[XLEN-1:2];
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (take_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= csr_new[3];
                    mstatus_mpie <= csr_new[7];
                end
                ADDR_MIE: begin
                    mie_meie <= csr_new[11];
                    mie_mtie <= csr_new[7];
                end
                ADDR_MTVEC:    mtvec    <= csr_new[XLEN-1:2];
                ADDR_MSCRATCH: mscratch <= csr_new;
                ADDR_MEPC:     mepc     <= csr_new[XLEN-1:2];
                ADDR_MCAUSE:   mcause   <= csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TRAP/RET are single-cycle flush states and ignore stall.
    always_comb begin
        state_next  = state;
        redirect    = 1'b0;
        redirect_pc = '0;
        trap_busy   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_trap) begin
                    state_next = ST_TRAP;
                end else if (take_mret) begin
                    state_next = ST_RET;
                end
            end
            ST_TRAP: begin
                state_next  = ST_IDLE;
                redirect    = 1'b1;
                redirect_pc = {mtvec, 2'b00};
                trap_busy   = 1'b1;
            end
            ST_RET: begin
                state_next  = ST_IDLE;
                redirect    = 1'b1;
                redirect_pc = {mepc, 2'b00};
                trap_busy   = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// tb_csr_trap_unit : directed and randomized checks of csr_trap_unit.
// Revision 1.0
// ============================================================================
module tb_csr_trap_unit;
    localparam int          XLEN           = 32;
    localparam logic [31:0] TB_RESET_MTVEC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid, stall, is_csr_instr, csr_write, is_mret_instr, is_ecall_instr;
    logic        ext_irq, timer_irq;
    logic [31:0] instr_pc, csr_wdata;
    logic [2:0]  func3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect, trap_busy;

    int n_checks = 0;
    int n_fail   = 0;

    csr_trap_unit #(.XLEN(XLEN), .RESET_MTVEC(TB_RESET_MTVEC)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall), .instr_pc(instr_pc),
        .is_csr_instr(is_csr_instr), .csr_write(csr_write), .func3(func3), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .is_mret_instr(is_mret_instr), .is_ecall_instr(is_ecall_instr),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_rdata(csr_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    // Reference model: CSR storage by address plus a pending-flush flag.
    logic [31:0] m_csr [int];
    bit          m_flush;
    logic [31:0] m_target;

    function automatic logic [31:0] m_mask(int a);
        case (a)
            'h300:        return 32'h0000_0088;
            'h304:        return 32'h0000_0880;
            'h305, 'h341: return 32'hFFFF_FFFC;
            'h340, 'h342: return 32'hFFFF_FFFF;
            default:      return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 'h344) return (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
        if (!m_csr.exists(a)) return 32'h0;
        return m_csr[a] | ((a == 'h300) ? 32'h1800 : 32'h0);
    endfunction

    task automatic m_reset();
        m_csr.delete();
        m_csr['h300] = 0; m_csr['h304] = 0; m_csr['h305] = TB_RESET_MTVEC & 32'hFFFF_FFFC;
        m_csr['h340] = 0; m_csr['h341] = 0; m_csr['h342] = 0;
        m_flush = 0; m_target = 0;
    endtask

    // Advance one clock: update the model from pre-edge inputs, then sample #1 after the edge.
    task automatic tick();
        logic [31:0] st, en, cause, old, nv;
        bit trap, wr;
        int a;
        trap = 0;
        if (m_flush) begin
            m_flush = 0; m_target = 0;
        end else if (instr_valid && !stall) begin
            st = m_csr['h300]; en = m_csr['h304];
            if (is_ecall_instr) begin trap = 1; cause = 32'd11; end
            else if (st[3] && en[11] && ext_irq) begin trap = 1; cause = 32'h8000_000B; end
            else if (st[3] && en[7] && timer_irq) begin trap = 1; cause = 32'h8000_0007; end
            if (trap) begin
                m_csr['h341] = instr_pc & 32'hFFFF_FFFC;
                m_csr['h342] = cause;
                m_csr['h300] = st[3] ? 32'h80 : 32'h0;
                m_flush = 1; m_target = m_csr['h305];
            end else if (is_mret_instr) begin
                m_csr['h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
                m_flush = 1; m_target = m_csr['h341];
            end else if (is_csr_instr && csr_write) begin
                a = int'(csr_addr); old = m_read(a); wr = 0; nv = old;
                case (func3[1:0])
                    2'b01: begin nv = csr_wdata; wr = 1; end
                    2'b10: begin nv = old | csr_wdata; wr = (csr_wdata != 0); end
                    2'b11: begin nv = old & ~csr_wdata; wr = (csr_wdata != 0); end
                    default: ;
                endcase
                if (wr && m_csr.exists(a)) m_csr[a] = nv & m_mask(a);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        instr_valid = 0; stall = 0; is_csr_instr = 0; csr_write = 0; func3 = 0;
        csr_wdata = 0; is_mret_instr = 0; is_ecall_instr = 0; instr_pc = 0;
    endtask

    task automatic drive_csr(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d);
        idle();
        instr_valid = 1; is_csr_instr = 1; csr_write = 1; func3 = f3; csr_addr = a; csr_wdata = d;
        instr_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic peek(input logic [11:0] a);
        csr_addr = a; #1;
    endtask

    task automatic test_reset();
        idle(); ext_irq = 0; timer_irq = 0; csr_addr = 0;
        reset = 1; #2; m_reset();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b exp 0", redirect); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h exp 0", redirect_pc); end
        n_checks++; if (trap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", trap_busy); end
        peek(12'h300);
        n_checks++; if (csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus: got %h exp 1800", csr_rdata); end
        peek(12'h305);
        n_checks++; if (csr_rdata !== TB_RESET_MTVEC) begin n_fail++; $display("FAIL reset_mtvec: got %h exp %h", csr_rdata, TB_RESET_MTVEC); end
        peek(12'h340);
        n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mscratch: got %h exp 0", csr_rdata); end
        #3 reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_csr_rmw();
        drive_csr(12'h340, 3'b001, 32'hDEAD_BEEF); #1;
        n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_old_value: got %h exp 0", csr_rdata); end
        tick();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL csr_no_redirect: got %b exp 0", redirect); end
        drive_csr(12'h340, 3'b010, 32'h0); #1;
        n_checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rs_old_value: got %h exp deadbeef", csr_rdata); end
        tick();
        drive_csr(12'h340, 3'b011, 32'h0000_FFFF); #1;
        n_checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rs_zero_nowrite: got %h exp deadbeef", csr_rdata); end
        tick();
        idle(); peek(12'h340);
        n_checks++; if (csr_rdata !== 32'hDEAD_0000) begin n_fail++; $display("FAIL rc_result: got %h exp dead0000", csr_rdata); end
        drive_csr(12'h344, 3'b001, 32'hFFFF_FFFF); tick();
        drive_csr(12'h7C0, 3'b001, 32'hFFFF_FFFF); tick();
        drive_csr(12'h300, 3'b001, 32'hFFFF_FFFF); tick();
        drive_csr(12'h304, 3'b001, 32'hFFFF_FFFF); tick();
        drive_csr(12'h305, 3'b001, 32'h0000_0103); tick();
        idle(); peek(12'h344);
        n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mip_readonly: got %h exp 0", csr_rdata); end
        peek(12'h7C0);
        n_checks++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h exp 0", csr_rdata); end
        peek(12'h300);
        n_checks++; if (csr_rdata !== 32'h1888) begin n_fail++; $display("FAIL mstatus_mask: got %h exp 1888", csr_rdata); end
        peek(12'h304);
        n_checks++; if (csr_rdata !== 32'h880) begin n_fail++; $display("FAIL mie_mask: got %h exp 880", csr_rdata); end
        drive_csr(12'h300, 3'b001, 32'h0); tick();
        drive_csr(12'h304, 3'b001, 32'h0); tick();
        idle(); peek(12'h305);
        n_checks++; if (csr_rdata !== 32'h100) begin n_fail++; $display("FAIL mtvec_align: got %h exp 100", csr_rdata); end
    endtask

    task automatic test_ecall();
        drive_csr(12'h300, 3'b001, 32'h8); tick();
        idle(); instr_valid = 1; is_ecall_instr = 1; instr_pc = 32'h2004; #1;
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL ecall_latency: got %b exp 0", redirect); end
        tick();
        n_checks++; if ({redirect, trap_busy} !== 2'b11) begin n_fail++; $display("FAIL ecall_redirect: got %b exp 11", {redirect, trap_busy}); end
        n_checks++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL ecall_target: got %h exp 100", redirect_pc); end
        drive_csr(12'h340, 3'b001, 32'h1234); tick();
        n_checks++; if ({redirect, trap_busy} !== 2'b00) begin n_fail++; $display("FAIL ecall_one_cycle: got %b exp 00", {redirect, trap_busy}); end
        idle(); peek(12'h341);
        n_checks++; if (csr_rdata !== 32'h2004) begin n_fail++; $display("FAIL ecall_mepc: got %h exp 2004", csr_rdata); end
        peek(12'h342);
        n_checks++; if (csr_rdata !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h exp b", csr_rdata); end
        peek(12'h300);
        n_checks++; if (csr_rdata !== 32'h1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h exp 1880", csr_rdata); end
        peek(12'h340);
        n_checks++; if (csr_rdata !== 32'hDEAD_0000) begin n_fail++; $display("FAIL busy_ignores_csr: got %h exp dead0000", csr_rdata); end
    endtask

    task automatic test_irq_vs_csr();
        drive_csr(12'h304, 3'b001, 32'h800); tick();
        drive_csr(12'h300, 3'b001, 32'h8); tick();
        ext_irq = 1; drive_csr(12'h305, 3'b001, 32'h500); instr_pc = 32'h40; tick();
        n_checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL ext_redirect: got %b/%h exp 1/100", redirect, redirect_pc); end
        ext_irq = 0; idle(); tick();
        peek(12'h342);
        n_checks++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL ext_mcause: got %h exp 8000000b", csr_rdata); end
        peek(12'h341);
        n_checks++; if (csr_rdata !== 32'h40) begin n_fail++; $display("FAIL ext_mepc: got %h exp 40", csr_rdata); end
        peek(12'h305);
        n_checks++; if (csr_rdata !== 32'h100) begin n_fail++; $display("FAIL trap_drops_write: got %h exp 100", csr_rdata); end
    endtask

    task automatic test_priority_mret();
        drive_csr(12'h304, 3'b001, 32'h880); tick();
        drive_csr(12'h300, 3'b001, 32'h8); tick();
        ext_irq = 1; timer_irq = 1; idle(); instr_valid = 1; instr_pc = 32'h40; tick();
        n_checks++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL both_irq_target: got %h exp 100", redirect_pc); end
        idle(); tick(); peek(12'h342);
        n_checks++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL ext_over_timer: got %h exp 8000000b", csr_rdata); end
        ext_irq = 0; instr_valid = 1; is_mret_instr = 1; instr_pc = 32'h44; tick();
        n_checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL mret_redirect: got %b/%h exp 1/40", redirect, redirect_pc); end
        idle(); instr_valid = 1; instr_pc = 32'h40; tick();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL ret_ignores_input: got %b exp 0", redirect); end
        peek(12'h300);
        n_checks++; if (csr_rdata !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h exp 1888", csr_rdata); end
        tick();
        n_checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL timer_after_ret: got %b/%h exp 1/100", redirect, redirect_pc); end
        idle(); tick(); peek(12'h342);
        n_checks++; if (csr_rdata !== 32'h8000_0007) begin n_fail++; $display("FAIL timer_mcause: got %h exp 80000007", csr_rdata); end
    endtask

    task automatic test_held_off();
        idle(); instr_valid = 1; instr_pc = 32'h80; tick();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL held_off_mie0: got %b exp 0", redirect); end
        drive_csr(12'h300, 3'b010, 32'h8); instr_pc = 32'h84; tick();
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL held_off_csr_cycle: got %b exp 0", redirect); end
        idle(); instr_valid = 1; instr_pc = 32'h88; tick();
        n_checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL taken_after_enable: got %b/%h exp 1/100", redirect, redirect_pc); end
        idle(); tick();
        drive_csr(12'h300, 3'b010, 32'h8); tick();
        idle(); instr_valid = 1; instr_pc = 32'h90; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL stall_blocks_%0d: got %b exp 0", i, redirect); end
        end
        stall = 0; tick();
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL taken_after_stall: got %b exp 1", redirect); end
        idle(); tick(); peek(12'h341);
        n_checks++; if (csr_rdata !== 32'h90) begin n_fail++; $display("FAIL stall_mepc: got %h exp 90", csr_rdata); end
        timer_irq = 0;
    endtask

    task automatic test_reset_mid_trap();
        idle(); instr_valid = 1; is_ecall_instr = 1; instr_pc = 32'h300; tick();
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL pre_reset_trap: got %b exp 1", redirect); end
        reset = 1; #1;
        n_checks++; if ({redirect, trap_busy} !== 2'b00) begin n_fail++; $display("FAIL async_reset_flags: got %b exp 00", {redirect, trap_busy}); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h exp 0", redirect_pc); end
        idle(); peek(12'h305);
        n_checks++; if (csr_rdata !== TB_RESET_MTVEC) begin n_fail++; $display("FAIL reset_mid_mtvec: got %h exp %h", csr_rdata, TB_RESET_MTVEC); end
        peek(12'h300);
        n_checks++; if (csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL reset_mid_mstatus: got %h exp 1800", csr_rdata); end
        m_reset(); #1 reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h000};
        logic [11:0] a;
        for (int i = 0; i < 600; i++) begin
            instr_valid    = ($urandom_range(0, 7) != 0);
            stall          = ($urandom_range(0, 5) == 0);
            is_ecall_instr = ($urandom_range(0, 19) == 0);
            is_mret_instr  = ($urandom_range(0, 11) == 0);
            is_csr_instr   = ($urandom_range(0, 1) == 1);
            csr_write      = ($urandom_range(0, 3) != 0);
            func3          = 3'($urandom);
            a              = addrs[$urandom_range(0, 7)];
            csr_addr       = (a == 12'h000) ? 12'($urandom) : a;
            csr_wdata      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            instr_pc       = $urandom;
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            #1;
            n_checks++; if (csr_rdata !== m_read(int'(csr_addr))) begin n_fail++; $display("FAIL rand_rdata[%0d] addr %h: got %h exp %h", i, csr_addr, csr_rdata, m_read(int'(csr_addr))); end
            tick();
            n_checks++; if ({redirect, trap_busy, redirect_pc} !== {m_flush, m_flush, m_target}) begin n_fail++; $display("FAIL rand_redirect[%0d]: got %b%b/%h exp %b/%h", i, redirect, trap_busy, redirect_pc, m_flush, m_target); end
        end
        idle(); ext_irq = 0; timer_irq = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_csr_rmw();
        test_ecall();
        test_irq_vs_csr();
        test_priority_mret();
        test_held_off();
        test_reset_mid_trap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer. It is the responder to the decode stage's CSR, MRET and ECALL indications (csr_write, csr_data_sel, is_csr_instr, is_mret_instr, is_ecall_instr).
- Holds the M-mode CSRs and executes CSR read-modify-write operations.
- Sequences trap entry (ECALL, external/timer interrupt) and MRET return.
- Issues a one-cycle PC redirect and pipeline flush toward fetch.

Parameters:
- XLEN, 32, data width of every CSR and PC.
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  the EX-stage instruction is real (not a bubble)
- stall  in  1  pipeline stalled; no event is accepted while high
- instr_pc  in  XLEN  PC of the EX-stage instruction
- is_csr_instr  in  1  CSR instruction
- csr_write  in  1  CSR write enable from decode
- func3  in  3  CSR op; bits [1:0]: 01=RW, 10=RS, 11=RC
- csr_addr  in  12  CSR address (instr[31:20])
- csr_wdata  in  XLEN  rs1 value or zero-extended zimm, already selected by csr_data_sel
- is_mret_instr  in  1  MRET
- is_ecall_instr  in  1  ECALL
- ext_irq  in  1  level machine external interrupt
- timer_irq  in  1  level machine timer interrupt
- csr_rdata  out  XLEN  old CSR value, for writeback to rd
- redirect  out  1  one-cycle PC redirect and flush
- redirect_pc  out  XLEN  redirect target
- trap_busy  out  1  FSM not IDLE

Behaviour:
- Reset: all CSRs clear; mtvec=RESET_MTVEC; mstatus.MPP reads 2'b11. Outputs: redirect=0, redirect_pc=0, trap_busy=0, FSM=IDLE.
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 11. Other bits read 0 and are not writable.
  - mie 0x304: MEIE bit11, MTIE bit7 writable; other bits 0.
  - mtvec 0x305: direct mode only; bits[1:0] read 0.
  - mscratch 0x340: full XLEN.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: full XLEN.
  - mip 0x344: read-only. MEIP bit11 = ext_irq, MTIP bit7 = timer_irq (live, unregistered).
  - Any other address reads 0; writes to it are ignored with no exception.
- Reads: csr_rdata is combinational from csr_addr and shows the pre-write value.
- Writes: a CSR op is accepted when instr_valid & ~stall & is_csr_instr & csr_write & no trap accepted this cycle. The CSR updates at the next rising edge:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 perform no write.
  - Writes to read-only mip are ignored.
- Event accept condition: instr_valid & ~stall & FSM==IDLE.
- Event priority (highest first):
  1. ECALL
  2. external interrupt (mstatus.MIE & mie.MEIE & ext_irq)
  3. timer interrupt (mstatus.MIE & mie.MTIE & timer_irq)
  4. MRET
  5. CSR op
- Only one event is accepted per cycle.
- Trap entry, updated at the edge of the accepting cycle:
  - mepc <= instr_pc. An interrupt squashes the EX instruction, so it re-executes after MRET.
  - mcause <= 32'd11 (ECALL), 32'h8000_000B (external) or 32'h8000_0007 (timer).
  - mstatus.MPIE <= MIE; MIE <= 0.
  - FSM IDLE -> TRAP.
- MRET, at the accepting edge:
  - MIE <= MPIE; MPIE <= 1.
  - FSM IDLE -> RET.
- TRAP and RET each last exactly one cycle:
  - redirect=1, redirect_pc = {mtvec[31:2],2'b00} (TRAP) or {mepc[31:2],2'b00} (RET).
  - trap_busy=1.
  - Next state is IDLE unconditionally, even if stall is high.
- Latency: event accepted in cycle N -> redirect high in cycle N+1 only.
- While FSM != IDLE, all inputs are ignored (the flush squashes them).
- CSR write to mtvec/mepc in the same cycle as a trap: the trap wins and the write is dropped.
- An interrupt pending while MIE=0 is held off. It is taken on the first accepted cycle after MIE becomes 1, including the cycle right after a RET.
- Reset asserted mid-TRAP/RET: the FSM returns to IDLE immediately, redirect drops asynchronously, and CSRs take their reset values.

Test Plan:
- CSRRW mscratch 0x340, wdata=0xDEADBEEF; then CSRRS with wdata=0 -> second op gives csr_rdata=0xDEADBEEF and no write occurs; CSRRC with wdata=0x0000FFFF -> mscratch=0xDEAD0000.
- mtvec=0x100, ECALL at instr_pc=0x2004 -> next cycle redirect=1, redirect_pc=0x100; mepc=0x2004, mcause=11, MIE=0, MPIE=old MIE; redirect lasts exactly one cycle.
- MIE=1, MEIE=1, ext_irq=1 with simultaneous CSRRW mtvec at pc=0x40 -> trap taken, mcause=0x8000000B, mepc=0x40, mtvec unchanged.
- ext_irq and timer_irq both pending and enabled -> mcause=0x8000000B; after MRET, redirect_pc=0x40 and MIE=1; with ext_irq deasserted, the timer trap is taken on the next accepted cycle with mcause=0x80000007.
- timer_irq=1, MTIE=1, MIE=0 -> no trap; CSRRS mstatus with 0x8 -> trap on the following accepted cycle. Repeat with stall=1 -> no trap until stall drops.
- Reset pulse during TRAP -> redirect=0 immediately, trap_busy=0, mtvec=RESET_MTVEC, mstatus reads 0x1800.
